// File: rtl/iir_pkg.sv
// Shared constants for the IIR coefficient controller: coefficient addresses,
// controller FSM states and the default sample/coefficient width.
package iir_pkg;

    localparam int NB_DEF   = 12;
    localparam int NUM_COEF = 5;

    localparam logic [2:0] ADDR_B0 = 3'd0;
    localparam logic [2:0] ADDR_B1 = 3'd1;
    localparam logic [2:0] ADDR_B2 = 3'd2;
    localparam logic [2:0] ADDR_A1 = 3'd3;
    localparam logic [2:0] ADDR_A2 = 3'd4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } cfg_state_e;

    function automatic logic addr_valid(input logic [2:0] addr);
        return addr <= ADDR_A2;
    endfunction

endpackage

// File: rtl/iir_inflight_cnt.sv
// Up/down counter of samples handed to the filter but not yet returned.
// Saturates at 0 and MAX, flags full and an unmatched decrement.
module iir_inflight_cnt #(
    parameter int MAX = 8,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          underflow
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d   = count_q;
        underflow = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (inc && !dec) begin
            if (count_q != CW'(MAX)) begin
                count_d = count_q + CW'(1);
            end
        end else if (dec && !inc) begin
            if (count_q == '0) begin
                underflow = 1'b1;
            end else begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign full  = (count_q == CW'(MAX));

endmodule

// File: rtl/iir_cfg_ctrl.sv
// Coefficient shadow/commit controller in front of iir_filter. Build option
// IIR_CFG_FLUSH_EN adds a FLUSH state that holds the filter in reset after a swap.
module iir_cfg_ctrl
    import iir_pkg::*;
#(
    parameter int NB           = NB_DEF,
    parameter int MAX_INFLIGHT = 8,
    parameter int DRAIN_TO     = 64,
    parameter int FLUSH_CYC    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [2:0]      cfg_addr,
    input  logic [NB-1:0]   cfg_wdata,
    input  logic            cfg_commit,
    output logic            cfg_busy,
    output logic            cfg_err,
    input  logic            s_valid,
    input  logic [NB-1:0]   s_data,
    output logic            s_ready,
    output logic            f_vIn,
    output logic [NB-1:0]   f_dIn,
    output logic [3*NB-1:0] f_b,
    output logic [2*NB-1:0] f_a,
    output logic            f_rst_n,
    input  logic            f_vOut
);

    localparam int CNT_W   = $clog2(MAX_INFLIGHT + 1);
    localparam int TMR_MAX = (DRAIN_TO > FLUSH_CYC) ? DRAIN_TO : FLUSH_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    cfg_state_e state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             err_q, err_d;
    logic             vin_q, vin_d;
    logic [NB-1:0]    din_q, din_d;

    logic [NUM_COEF-1:0][NB-1:0] shadow_q, shadow_d;
    logic [NUM_COEF-1:0][NB-1:0] act_q, act_d;

    logic [CNT_W-1:0] inflight;
    logic             cnt_full;
    logic             cnt_underflow;
    logic             accept;
    logic             drained;
    logic             copy;
    logic             drain_timeout;
    logic             bad_write;
    logic             commit_err;

    assign s_ready = (state_q == RUN) && !cnt_full;
    assign accept  = s_valid && s_ready;

    // A sample is counted as it is registered onto f_vIn, so the count also
    // covers the output register stage and drain cannot race a pending sample.
    iir_inflight_cnt #(
        .MAX (MAX_INFLIGHT),
        .CW  (CNT_W)
    ) u_inflight (
        .clk       (clk),
        .rst       (rst),
        .inc       (accept),
        .dec       (f_vOut),
        .clr       (drain_timeout),
        .count     (inflight),
        .full      (cnt_full),
        .underflow (cnt_underflow)
    );

    assign drained = (inflight == '0) && !vin_q;

    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        copy          = 1'b0;
        drain_timeout = 1'b0;
        unique case (state_q)
            RUN: begin
                if (cfg_commit) begin
                    state_d = DRAIN;
                    tmr_d   = '0;
                end
            end
            DRAIN: begin
                if (drained || (tmr_q == TMR_W'(DRAIN_TO - 1))) begin
                    copy          = 1'b1;
                    drain_timeout = !drained;
                    tmr_d         = '0;
`ifdef IIR_CFG_FLUSH_EN
                    state_d       = FLUSH;
`else
                    state_d       = RUN;
`endif
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            FLUSH: begin
                if (tmr_q == TMR_W'(FLUSH_CYC - 1)) begin
                    state_d = RUN;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                tmr_d   = '0;
            end
        endcase
    end

    // The copy takes shadow_d so a write landing on the copy cycle is included.
    for (genvar gi = 0; gi < NUM_COEF; gi++) begin : g_coef
        assign shadow_d[gi] = (cfg_we && (cfg_addr == 3'(gi))) ? cfg_wdata : shadow_q[gi];
        assign act_d[gi]    = copy ? shadow_d[gi] : act_q[gi];
    end

    assign bad_write  = cfg_we && !addr_valid(cfg_addr);
    assign commit_err = cfg_commit && (state_q != RUN);

    always_comb begin
        err_d = err_q | bad_write | commit_err | cnt_underflow | drain_timeout;
        vin_d = accept;
        din_d = accept ? s_data : din_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            tmr_q    <= '0;
            err_q    <= 1'b0;
            vin_q    <= 1'b0;
            din_q    <= '0;
            shadow_q <= '0;
            act_q    <= '0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            err_q    <= err_d;
            vin_q    <= vin_d;
            din_q    <= din_d;
            shadow_q <= shadow_d;
            act_q    <= act_d;
        end
    end

    assign cfg_busy = (state_q != RUN);
    assign cfg_err  = err_q;
    assign f_vIn    = vin_q;
    assign f_dIn    = din_q;
    assign f_b      = {act_q[ADDR_B2], act_q[ADDR_B1], act_q[ADDR_B0]};
    assign f_a      = {act_q[ADDR_A2], act_q[ADDR_A1]};

`ifdef IIR_CFG_FLUSH_EN
    assign f_rst_n = !rst && (state_q != FLUSH);
`else
    assign f_rst_n = !rst;
`endif

endmodule

// File: doc/iir_cfg_ctrl.md
# iir_cfg_ctrl

Coefficient-configuration and stream-sequencing controller placed between the sample source and `iir_filter`. It holds shadow copies of the five filter coefficients written over a simple register port. On commit it stalls input, drains samples in flight in the filter and swaps in the new coefficient set atomically. When compiled in, it also flushes the filter's state registers, so no output sample is ever computed with a mix of old and new coefficients.

## Interface
- `NB`, 12, sample/coefficient width (matches `iir_filter`)
- `MAX_INFLIGHT`, 8, max samples accepted but not yet returned on `f_vOut`
- `DRAIN_TO`, 64, drain timeout in cycles
- `FLUSH_CYC`, 4, cycles `f_rst_n` is held low during flush

Ports:
- `clk`  in  1  sole clock, all logic rising-edge
- `rst`  in  1  reset, synchronous and active-high
- `cfg_we`  in  1  shadow-register write strobe
- `cfg_addr`  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2, 5–7 invalid
- `cfg_wdata`  in  NB  write data
- `cfg_commit`  in  1  one-cycle request to apply shadow set
- `cfg_busy`  out  1  commit sequence in progress
- `cfg_err`  out  1  sticky error flag, cleared only by `rst`
- `s_valid`  in  1  input sample valid
- `s_data`  in  NB  input sample
- `s_ready`  out  1  controller accepts sample this cycle
- `f_vIn`  out  1  to filter `vIn`
- `f_dIn`  out  NB  to filter `dIn`
- `f_b`  out  3*NB  to filter `b`, {b2,b1,b0}, b0 in LSBs
- `f_a`  out  2*NB  to filter `a`, {a2,a1}, a1 in LSBs
- `f_rst_n`  out  1  to filter `rst_n`
- `f_vOut`  in  1  filter output valid (in-flight accounting only)

## Operation
- FSM states: RUN, DRAIN, FLUSH.
- **RUN**
  - `s_ready = (state==RUN) && (inflight < MAX_INFLIGHT)`, combinational.
  - Accept when `s_valid && s_ready`. Accepted samples register onto `f_vIn`/`f_dIn`.
- **In-flight counter**
  - `+1` on registered `f_vIn`, `-1` on `f_vOut`.
  - Both in the same cycle: no change.
  - `f_vOut` with count 0: ignored, counter saturates at 0, `cfg_err` set.
- **Shadow registers**
  - Five NB-bit shadow registers. `cfg_we` writes in any state.
  - Writes never affect `f_b`/`f_a` directly.
  - A write to addr 5–7 is dropped and sets `cfg_err`.
- **Commit**
  - `cfg_commit` in RUN: go to DRAIN; `cfg_busy` rises next cycle.
  - `cfg_commit` while busy: ignored, sets `cfg_err`.
- **DRAIN**
  - `s_ready=0`.
  - Wait until `inflight==0`, or until `DRAIN_TO` cycles have elapsed. On timeout set `cfg_err` and force `inflight` to 0.
  - On exit, copy shadow to active (`f_b`/`f_a`) in a single cycle, then go to FLUSH (or RUN, see Configuration).
- **FLUSH**: `f_rst_n=0` for `FLUSH_CYC` cycles, then return to RUN with `cfg_busy=0`.
- **Shadow writes during a commit**: if a shadow write coincides with the copy cycle, the new value is copied. Later writes wait for the next commit.

## Timing
- Reset values: state=RUN, `cfg_busy=0`, `cfg_err=0`, `f_vIn=0`, `f_dIn=0`, shadow=0, `f_b=0`, `f_a=0`, `inflight=0`, `f_rst_n=0`. `f_rst_n` rises on the first cycle after `rst` deasserts.
- Sample path latency: 1 cycle, from `s_valid && s_ready` at edge N to `f_vIn=1` at edge N+1.
- Commit sequence, with in-flight count 0 at commit:
  - Commit at N, DRAIN at N+1.
  - Copy at N+1 exit; `f_b`/`f_a` updated at N+2.
  - With flush, `f_rst_n` is low for N+2 … N+1+FLUSH_CYC, and `s_ready` returns at N+2+FLUSH_CYC.
- `f_b`/`f_a` change only while `f_vIn=0` and the filter holds no in-flight samples.
- `rst` mid-sequence: immediate return to the reset values above. The active set is lost (back to 0).

## Configuration
- `IIR_CFG_FLUSH_EN` defined: FLUSH state exists as above.
- Undefined: DRAIN exits directly to RUN after the copy, with the same copy timing. `f_rst_n` only mirrors reset (low during `rst`, high otherwise), so filter state carries over across a coefficient change. `FLUSH_CYC` is unused.

## Structure
- Package `iir_pkg`:
  - coefficient address constants (`ADDR_B0` … `ADDR_A2`)
  - FSM state enum
  - default NB
- Sub-module `iir_inflight_cnt`: up/down counter with saturation, full flag (`==MAX_INFLIGHT`) and underflow flag.
- Everything else stays in `iir_cfg_ctrl`. The top-level bench instantiates it between `data_maker` and `iir_filter`.

## Test plan
- **Write and commit at idle**: write b0=0x100, b1=0x080, b2=0x040, a1=0xF00, a2=0x020, then commit with idle stream.
  - `f_b=0x040080100`, `f_a=0x020F00` two cycles after commit.
  - `f_rst_n` low for exactly 4 cycles; `cfg_busy` low afterwards.
- **Commit with samples in flight**: commit while 3 samples are in flight.
  - `s_ready` stays 0 until the third `f_vOut`.
  - `f_b`/`f_a` unchanged before that point; no `cfg_err`.
- **Backpressure**: stream with `f_vOut` held low.
  - `s_ready` drops after 8 accepted samples and recovers one cycle after an `f_vOut`.
- **Error flags**:
  - Write to addr 6: `cfg_err=1`, active and shadow unchanged.
  - Second commit during DRAIN: ignored, `cfg_err=1`.
- **Drain timeout**: commit with 1 in-flight sample and `f_vOut` never asserted.
  - Coefficients apply at 64 cycles; `cfg_err=1`.
- **Reset mid-flush**: assert `rst` during FLUSH.
  - All outputs take reset values next edge; `s_ready=1` the cycle after `rst` deasserts.
